// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 types, sizes, schedule FSM states and sigma functions
// Contents: word_t, ROUNDS, WIN, ws_state_e, sig0(), sig1()
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam int ROUNDS = 64;
    localparam int WIN    = 16;

    typedef enum logic [1:0] {
        WS_IDLE,
        WS_RUN,
        WS_DONE
    } ws_state_e;

    // sigma0: ROTR7 ^ ROTR18 ^ SHR3
    function automatic word_t sig0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    // sigma1: ROTR17 ^ ROTR19 ^ SHR10
    function automatic word_t sig1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

endpackage

// File: rtl/w_schedule_if.sv
// rtl/w_schedule_if.sv - strobe/data bundle between round controller and message schedule
// Signals: init, next, block[511:0] (controller -> schedule); w_i, round, busy, done (schedule -> controller)
interface w_schedule_if;
    import sha256_pkg::*;

    logic         init;
    logic         next;
    logic [511:0] block;
    word_t        w_i;
    logic [5:0]   round;
    logic         busy;
    logic         done;

    modport master (
        output init, next, block,
        input  w_i, round, busy, done
    );

    modport slave (
        input  init, next, block,
        output w_i, round, busy, done
    );
endinterface

// File: rtl/w_expand.sv
// rtl/w_expand.sv - combinational SHA-256 schedule expansion word
// Ports: w0, w1, w9, w14 in (window taps); w_new out = sig1(w14) + w9 + sig0(w1) + w0 mod 2^32
module w_expand
    import sha256_pkg::*;
(
    input  word_t w0,
    input  word_t w1,
    input  word_t w9,
    input  word_t w14,
    output word_t w_new
);
    assign w_new = sig1(w14) + w9 + sig0(w1) + w0;
endmodule

// File: rtl/w_schedule.sv
// rtl/w_schedule.sv - SHA-256 message schedule: 16-word sliding window, round counter, FSM
// Ports: clk, Reset (sync, active-high), bus (w_schedule_if.slave: init/next/block in, w_i/round/busy/done out)
module w_schedule
    import sha256_pkg::*;
(
    input  logic          clk,
    input  logic          Reset,
    w_schedule_if.slave   bus
);
    ws_state_e  state, state_n;
    word_t      win [WIN];
    logic [5:0] round;
    logic       load;
    logic       adv;
    word_t      w_new;

    w_expand u_expand (
        .w0    (win[0]),
        .w1    (win[1]),
        .w9    (win[9]),
        .w14   (win[14]),
        .w_new (w_new)
    );

    // init is honoured in every state and shadows a coincident next
    always_comb begin
        state_n = state;
        load    = 1'b0;
        adv     = 1'b0;
        if (bus.init) begin
            load    = 1'b1;
            state_n = WS_RUN;
        end else if (bus.next && state == WS_RUN) begin
            adv = 1'b1;
            if (round == 6'(ROUNDS - 1)) begin
                state_n = WS_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= WS_IDLE;
            round <= '0;
            for (int k = 0; k < WIN; k++) begin
                win[k] <= '0;
            end
        end else begin
            state <= state_n;
            if (load) begin
                round <= '0;
                for (int k = 0; k < WIN; k++) begin
                    win[k] <= bus.block[511 - 32*k -: 32];
                end
            end else if (adv) begin
                // 6-bit counter wraps 63 -> 0 on the final advance
                round <= round + 6'd1;
                for (int k = 0; k < WIN - 1; k++) begin
                    win[k] <= win[k+1];
                end
                win[WIN-1] <= w_new;
            end
        end
    end

    assign bus.w_i   = win[0];
    assign bus.round = round;
    assign bus.busy  = (state == WS_RUN);
    assign bus.done  = (state == WS_DONE);
endmodule

// File: tb/tb_w_schedule.sv
// tb/tb_w_schedule.sv - self-checking bench for w_schedule against a full-array schedule model
module tb_w_schedule;
    logic clk;
    logic Reset;
    int   errors;
    int   checks;

    logic [31:0]  mw [80];
    logic [511:0] blk_a;
    logic [511:0] blk_b;

    w_schedule_if bus ();

    w_schedule dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Whole schedule W[0..79]; W[64] is what the window head holds after the last advance
    task automatic build_model(input logic [511:0] b);
        for (int t = 0; t < 16; t++) mw[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 80; t++)
            mw[t] = s1(mw[t-2]) + mw[t-7] + s0(mw[t-15]) + mw[t-16];
    endtask

    task automatic rand_block(output logic [511:0] b);
        for (int k = 0; k < 16; k++) b[511 - 32*k -: 32] = $urandom();
    endtask

    task automatic cycle(input logic i, input logic n);
        bus.init = i;
        bus.next = n;
        @(posedge clk);
        #1;
        bus.init = 1'b0;
        bus.next = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        Reset = 1'b0;
        checks += 4;
        if (bus.w_i !== 32'h0)  begin errors++; $display("FAIL reset_w_i got=%h exp=0", bus.w_i); end
        if (bus.round !== 6'd0) begin errors++; $display("FAIL reset_round got=%0d exp=0", bus.round); end
        if (bus.busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        if (bus.done !== 1'b0)  begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        cycle(1'b0, 1'b1);
        checks++;
        if (bus.round !== 6'd0) begin errors++; $display("FAIL idle_next_round got=%0d exp=0", bus.round); end
    endtask

    task automatic test_reset_mid_run;
        rand_block(blk_a);
        bus.block = blk_a;
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1);
        checks++;
        if (bus.round !== 6'd10) begin errors++; $display("FAIL midrun_round got=%0d exp=10", bus.round); end
        Reset = 1'b1;
        cycle(1'b0, 1'b1);
        Reset = 1'b0;
        checks += 4;
        if (bus.w_i !== 32'h0)  begin errors++; $display("FAIL rst_run_w_i got=%h exp=0", bus.w_i); end
        if (bus.round !== 6'd0) begin errors++; $display("FAIL rst_run_round got=%0d exp=0", bus.round); end
        if (bus.busy !== 1'b0)  begin errors++; $display("FAIL rst_run_busy got=%b exp=0", bus.busy); end
        if (bus.done !== 1'b0)  begin errors++; $display("FAIL rst_run_done got=%b exp=0", bus.done); end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
        checks += 2;
        if (bus.round !== 6'd0) begin errors++; $display("FAIL rst_ignore_round got=%0d exp=0", bus.round); end
        if (bus.w_i !== 32'h0)  begin errors++; $display("FAIL rst_ignore_w_i got=%h exp=0", bus.w_i); end
    endtask

    task automatic test_abc;
        blk_a = '0;
        blk_a[511:480] = 32'h61626380;
        blk_a[31:0]    = 32'h00000018;
        build_model(blk_a);
        bus.block = blk_a;
        cycle(1'b1, 1'b0);
        checks += 3;
        if (bus.w_i !== 32'h61626380) begin errors++; $display("FAIL abc_w0 got=%h exp=61626380", bus.w_i); end
        if (bus.round !== 6'd0)       begin errors++; $display("FAIL abc_round0 got=%0d exp=0", bus.round); end
        if (bus.busy !== 1'b1)        begin errors++; $display("FAIL abc_busy got=%b exp=1", bus.busy); end
        for (int t = 1; t <= 64; t++) begin
            cycle(1'b0, 1'b1);
            checks++;
            if (bus.w_i !== mw[t]) begin errors++; $display("FAIL abc_w%0d got=%h exp=%h", t, bus.w_i, mw[t]); end
            if (t == 15) begin
                checks++;
                if (bus.w_i !== 32'h00000018) begin errors++; $display("FAIL abc_w15_const got=%h exp=00000018", bus.w_i); end
            end
            if (t == 16) begin
                checks++;
                if (bus.w_i !== 32'h61626380) begin errors++; $display("FAIL abc_w16_const got=%h exp=61626380", bus.w_i); end
            end
            if (t == 17) begin
                checks++;
                if (bus.w_i !== 32'h000F0000) begin errors++; $display("FAIL abc_w17_const got=%h exp=000f0000", bus.w_i); end
            end
            if (t < 64) begin
                checks++;
                if (bus.round !== 6'(t) || bus.busy !== 1'b1) begin
                    errors++; $display("FAIL abc_round%0d got=%0d busy=%b exp=%0d busy=1", t, bus.round, bus.busy, t);
                end
            end
        end
        checks += 3;
        if (bus.done !== 1'b1)  begin errors++; $display("FAIL abc_done got=%b exp=1", bus.done); end
        if (bus.busy !== 1'b0)  begin errors++; $display("FAIL abc_busy_end got=%b exp=0", bus.busy); end
        if (bus.round !== 6'd0) begin errors++; $display("FAIL abc_round_wrap got=%0d exp=0", bus.round); end
        cycle(1'b0, 1'b1);
        checks += 3;
        if (bus.w_i !== mw[64]) begin errors++; $display("FAIL abc_65th_w_i got=%h exp=%h", bus.w_i, mw[64]); end
        if (bus.round !== 6'd0) begin errors++; $display("FAIL abc_65th_round got=%0d exp=0", bus.round); end
        if (bus.done !== 1'b1)  begin errors++; $display("FAIL abc_65th_done got=%b exp=1", bus.done); end
    endtask

    task automatic test_init_next_collision;
        rand_block(blk_a);
        rand_block(blk_b);
        bus.block = blk_a;
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1);
        build_model(blk_b);
        bus.block = blk_b;
        cycle(1'b1, 1'b1);
        checks += 3;
        if (bus.round !== 6'd0) begin errors++; $display("FAIL coll_round got=%0d exp=0", bus.round); end
        if (bus.w_i !== mw[0])  begin errors++; $display("FAIL coll_w_i got=%h exp=%h", bus.w_i, mw[0]); end
        if (bus.busy !== 1'b1)  begin errors++; $display("FAIL coll_busy got=%b exp=1", bus.busy); end
        cycle(1'b0, 1'b1);
        checks++;
        if (bus.w_i !== mw[1])  begin errors++; $display("FAIL coll_w1 got=%h exp=%h", bus.w_i, mw[1]); end
    endtask

    task automatic test_random_gaps;
        rand_block(blk_a);
        build_model(blk_a);
        bus.block = blk_a;
        cycle(1'b1, 1'b0);
        for (int t = 1; t <= 64; t++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0);
            checks++;
            if (bus.w_i !== mw[t-1]) begin errors++; $display("FAIL gap_hold_w%0d got=%h exp=%h", t-1, bus.w_i, mw[t-1]); end
            cycle(1'b0, 1'b1);
            checks++;
            if (bus.w_i !== mw[t]) begin errors++; $display("FAIL gap_w%0d got=%h exp=%h", t, bus.w_i, mw[t]); end
        end
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL gap_done got done=%b busy=%b exp done=1 busy=0", bus.done, bus.busy);
        end
        rand_block(blk_b);
        build_model(blk_b);
        bus.block = blk_b;
        cycle(1'b1, 1'b0);
        checks += 4;
        if (bus.w_i !== mw[0])  begin errors++; $display("FAIL restart_w_i got=%h exp=%h", bus.w_i, mw[0]); end
        if (bus.round !== 6'd0) begin errors++; $display("FAIL restart_round got=%0d exp=0", bus.round); end
        if (bus.busy !== 1'b1)  begin errors++; $display("FAIL restart_busy got=%b exp=1", bus.busy); end
        if (bus.done !== 1'b0)  begin errors++; $display("FAIL restart_done got=%b exp=0", bus.done); end
        cycle(1'b0, 1'b1);
        checks++;
        if (bus.w_i !== mw[1])  begin errors++; $display("FAIL restart_w1 got=%h exp=%h", bus.w_i, mw[1]); end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        Reset     = 1'b1;
        bus.init  = 1'b0;
        bus.next  = 1'b0;
        bus.block = '0;
        test_reset();
        test_reset_mid_run();
        test_abc();
        test_init_next_collision();
        test_random_gaps();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
